// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle RV32I controller: state encoding,
// opcode values, the ALUOp selector and the ALUControl operation codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] F3_BNE  = 3'b001;

endpackage

// File: rtl/mc_aludec.sv
// ALUControl decode from ALUOp plus funct3/funct7b5; purely combinational, zero latency,
// no flow control.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // funct7b5 only selects sub for register-register ops; addi ignores it
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I Moore control FSM: 2-5 cycles per instruction, no backpressure.
// Define MC_BNE_EN to let the BEQ state also resolve bne (taken on ~Zero when funct3=001).
module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] dbg_state
);

  state_t state, state_nxt;
  aluop_t aluop;
  logic   pcupdate, branch, taken;
  logic   irwrite_raw, regwrite_raw, memwrite_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = S_FETCH;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    aluop        = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        pcupdate    = 1'b1;
        state_nxt   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTER;
          OP_ITYPE:     state_nxt = S_EXECUTEI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BEQ:       state_nxt = S_BEQ;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWR;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA   = 2'b10;
        aluop     = ALUOP_FUNC;
        state_nxt = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        aluop     = ALUOP_FUNC;
        state_nxt = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcupdate  = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

`ifdef MC_BNE_EN
  assign taken = (funct3 == F3_BNE) ? ~Zero : Zero;
`else
  assign taken = Zero;
`endif

  // reset sits the FSM in Fetch but must not let that state's writes escape
  assign PCWrite  = ~reset & (pcupdate | (branch & taken));
  assign IRWrite  = ~reset & irwrite_raw;
  assign RegWrite = ~reset & regwrite_raw;
  assign MemWrite = ~reset & memwrite_raw;

  always_comb begin
    case (op)
      OP_LW, OP_ITYPE: ImmSrc = 2'b00;
      OP_SW:           ImmSrc = 2'b01;
      OP_BEQ:          ImmSrc = 2'b10;
      OP_JAL:          ImmSrc = 2'b11;
      default:         ImmSrc = 2'b00;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (ALUControl)
  );

  assign dbg_state = STATE_W'(state);

endmodule

// File: tb/tb_mc_controller.sv
// Directed plus randomized instruction sequences checked against a per-instruction
// state-path model and a per-state output table.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] dbg_state;

  int total = 0;
  int bad   = 0;

  mc_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // state numbering follows the order the states are listed in
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWR = 5;
  localparam int EXECR = 6, EXECI = 7, JAL = 8, ALUWB = 9, BEQ = 10;
  localparam int K_ADD = 0, K_SUB = 1, K_FUNC = 2;

  typedef int iq_t[$];

  // {PCUpdate, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB}
  logic [10:0] row [0:10];
  int          kind [0:10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic iq_t path_of(input logic [6:0] o);
    iq_t q;
    case (o)
      7'b0000011: q = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
      7'b0100011: q = '{FETCH, DECODE, MEMADR, MEMWR};
      7'b0110011: q = '{FETCH, DECODE, EXECR, ALUWB};
      7'b0010011: q = '{FETCH, DECODE, EXECI, ALUWB};
      7'b1101111: q = '{FETCH, DECODE, JAL, ALUWB};
      7'b1100011: q = '{FETCH, DECODE, BEQ};
      default:    q = '{FETCH, DECODE};
    endcase
    return q;
  endfunction

  function automatic logic taken_f(input logic [2:0] f3, input logic z);
`ifdef MC_BNE_EN
    return (f3 == 3'b001) ? !z : z;
`else
    return z;
`endif
  endfunction

  function automatic logic [1:0] imm_f(input logic [6:0] o);
    if (o == 7'b0000011 || o == 7'b0010011) return 2'b00;
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_f(input int k, input logic [6:0] o,
                                       input logic [2:0] f3, input logic f7);
    if (k == K_ADD) return 3'b000;
    if (k == K_SUB) return 3'b001;
    if (f3 == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [10:0] obs_ctl();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB};
  endfunction

  task automatic check_state(input int s, input string tag);
    logic [10:0] e;
    string t;
    t = $sformatf("%s@s%0d", tag, s);
    e = row[s];
    e[10] = e[10] | ((s == BEQ) && taken_f(funct3, Zero));
    chk({t, "/state"}, 32'(dbg_state), 32'(s));
    chk({t, "/ctl"}, 32'(obs_ctl()), 32'(e));
    chk({t, "/alu"}, 32'(ALUControl), 32'(alu_f(kind[s], op, funct3, funct7b5)));
    chk({t, "/imm"}, 32'(ImmSrc), 32'(imm_f(op)));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "/state"}, 32'(dbg_state), 32'(FETCH));
    chk({tag, "/ctl"}, 32'(obs_ctl()), 32'(row[FETCH] & ~11'b100_1000_0000));
    chk({tag, "/alu"}, 32'(ALUControl), 32'd0);
    chk({tag, "/imm"}, 32'(ImmSrc), 32'(imm_f(op)));
  endtask

  // starts with the DUT in Fetch, away from a clock edge; ends the same way
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    iq_t p;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    #1;
    p = path_of(o);
    foreach (p[i]) begin
      check_state(p[i], tag);
      @(posedge clk); #1;
    end
    chk({tag, "/end"}, 32'(dbg_state), 32'(FETCH));
  endtask

  initial begin
    logic [6:0] ops [0:5];
    logic [2:0] f3s [0:4];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    f3s = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

    row[FETCH]   = 11'b1_0_0_1_0_10_00_10; kind[FETCH]   = K_ADD;
    row[DECODE]  = 11'b0_0_0_0_0_00_01_01; kind[DECODE]  = K_ADD;
    row[MEMADR]  = 11'b0_0_0_0_0_00_10_01; kind[MEMADR]  = K_ADD;
    row[MEMREAD] = 11'b0_1_0_0_0_00_00_00; kind[MEMREAD] = K_ADD;
    row[MEMWB]   = 11'b0_0_0_0_1_01_00_00; kind[MEMWB]   = K_ADD;
    row[MEMWR]   = 11'b0_1_1_0_0_00_00_00; kind[MEMWR]   = K_ADD;
    row[EXECR]   = 11'b0_0_0_0_0_00_10_00; kind[EXECR]   = K_FUNC;
    row[EXECI]   = 11'b0_0_0_0_0_00_10_01; kind[EXECI]   = K_FUNC;
    row[JAL]     = 11'b1_0_0_0_0_00_01_10; kind[JAL]     = K_ADD;
    row[ALUWB]   = 11'b0_0_0_0_1_00_00_00; kind[ALUWB]   = K_ADD;
    row[BEQ]     = 11'b0_0_0_0_0_00_10_00; kind[BEQ]     = K_SUB;

    reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    #10;
    check_reset("rst_init");
    #12;
    reset = 1'b0;
    #1;

    run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0);
    run_instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0);
    run_instr("beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1);
    run_instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0);
    run_instr("bne_z0",  7'b1100011, 3'b001, 1'b0, 1'b0);
    run_instr("bne_z1",  7'b1100011, 3'b001, 1'b0, 1'b1);
    run_instr("sub",     7'b0110011, 3'b000, 1'b1, 1'b0);
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0);
    run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0);
    run_instr("unknown", 7'b1111111, 3'b000, 1'b0, 1'b0);

    // reset dropped in the middle of a load, while in MemRead
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid/pre", 32'(dbg_state), 32'(MEMREAD));
    reset = 1'b1;
    #1;
    check_reset("rst_mid");
    @(posedge clk); #1;
    check_reset("rst_hold");
    reset = 1'b0;
    #1;
    run_instr("after_rst", 7'b0000011, 3'b010, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      logic [2:0] f;
      int sel;
      sel = $urandom_range(0, 7);
      o = (sel < 6) ? ops[sel] : 7'($urandom);
      sel = $urandom_range(0, 5);
      f = (sel < 5) ? f3s[sel] : 3'($urandom);
      run_instr($sformatf("rnd%0d", n), o, f, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter STATE_W, default 4, width of the state register and of the dbg_state port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  instruction opcode, bits [6:0].
REQ-005 funct3  input  3  instruction bits [14:12].
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-010 ALUControl  output  3  ALU operation.
REQ-011 dbg_state  output  STATE_W  current state encoding.

Function
REQ-012 The block SHALL be a Moore FSM sequencing a multicycle RV32I subset: lw, sw, R-type, I-type ALU, beq, jal.
REQ-013 States SHALL be Fetch, Decode, MemAdr, MemRead, MemWB, MemWr, ExecuteR, ExecuteI, JAL, ALUWB, BEQ.
REQ-014 Fetch: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1; next state Decode.
REQ-015 Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=add. Next state by opcode: 0000011/0100011->MemAdr, 0110011->ExecuteR, 0010011->ExecuteI, 1101111->JAL, 1100011->BEQ, any other->Fetch (executed as a no-op).
REQ-016 MemAdr: ALUSrcA=10, ALUSrcB=01, add; next MemRead if op=0000011, else MemWr.
REQ-017 MemRead: ResultSrc=00, AdrSrc=1; next MemWB. MemWB: ResultSrc=01, RegWrite=1; next Fetch.
REQ-018 MemWr: ResultSrc=00, AdrSrc=1, MemWrite=1; next Fetch.
REQ-019 ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=func. ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=func. Both go next to ALUWB.
REQ-020 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1; next ALUWB. ALUWB: ResultSrc=00, RegWrite=1; next Fetch.
REQ-021 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1; next Fetch.
REQ-022 PCWrite SHALL equal PCUpdate | (Branch & taken), where taken=Zero.
REQ-023 Latency SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles; unknown opcode 2 cycles.
REQ-024 ImmSrc SHALL decode combinationally from op: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-025 ALUControl SHALL decode as follows: add->000, sub->001. func mode uses funct3: 000 gives 001 if op[5]&funct7b5 else 000; 010->101; 110->011; 111->010; else 000.
REQ-026 Any output not listed for a state SHALL be 0.

Reset
REQ-027 Asserting reset at any time, including mid-instruction, SHALL force state to Fetch immediately.
REQ-028 While reset is high, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0. All other outputs SHALL take their Fetch values, and dbg_state SHALL read Fetch.
REQ-029 After reset deasserts, the first rising edge SHALL execute Fetch.

Configuration
REQ-030 Macro MC_BNE_EN SHALL control bne support.
REQ-031 With MC_BNE_EN defined, BEQ-state taken SHALL be ~Zero when funct3=001, and Zero otherwise.
REQ-032 Without MC_BNE_EN, taken SHALL be Zero regardless of funct3.

Structure
REQ-033 Package mc_pkg SHALL hold the state enum, opcode constants, the ALUOp encoding (add/sub/func) and the ALUControl constants.
REQ-034 ALUControl decode SHALL be a sub-module named mc_aludec. The FSM and ImmSrc decode SHALL reside in mc_controller.

Verification
REQ-035 reset high 22 ns, then op=0000011 -> states Fetch, Decode, MemAdr, MemRead, MemWB, Fetch; RegWrite=1 only in cycle 4.
REQ-036 op=0100011 -> MemWrite=1 and AdrSrc=1 only in cycle 3; RegWrite stays 0 throughout.
REQ-037 op=1100011, funct3=000, Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0; next state Fetch.
REQ-038 With MC_BNE_EN defined, funct3=001 and Zero=0 -> PCWrite=1 in BEQ. With the macro undefined -> PCWrite=0.
REQ-039 op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in ExecuteR. op=0010011, funct3=000, funct7b5=1 -> ALUControl=000.
REQ-040 reset asserted during MemRead -> state becomes Fetch with no clock edge, and write enables are 0. op=1111111 -> Fetch, Decode, Fetch.
